// File: rtl/rx_fifo_ctrl_if.sv
// Push/pop/level bundle between the RX sequencing controller and the RX FIFO storage.
interface rx_fifo_ctrl_if #(
    parameter int DEPTH_W = 5
);
    logic               wr_en;
    logic [10:0]        wr_data;
    logic               rd_en;
    logic [10:0]        rd_data;
    logic [DEPTH_W:0]   level;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  level
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output level
    );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// UART RX FIFO sequencing: push/overrun, 3-cycle pop handshake, sticky line errors, RX interrupt.
// Optional character timeout is compiled in when RX_TIMEOUT_EN is defined.
module rx_fifo_ctrl #(
    parameter int DEPTH_W  = 5,
    parameter int TO_CHARS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_rx_valid,
    input  logic [10:0]         i_rx_data,
    rx_fifo_ctrl_if.master      io_fifo,
    input  logic                i_rd_req,
    output logic [7:0]          o_rd_data,
    output logic                o_rd_valid,
    input  logic [DEPTH_W:0]    i_thresh,
    input  logic                i_char_tick,
    input  logic                i_err_clr,
    output logic                o_data_ready,
    output logic                o_overrun,
    output logic                o_pe,
    output logic                o_fe,
    output logic                o_bi,
    output logic                o_timeout,
    output logic                o_irq_rx
);
    localparam int DEPTH = 2**DEPTH_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_CAPT,
        ST_DONE
    } state_t;

    // ---------------- push path ----------------
    logic                   r_wr_en;
    logic [10:0]            r_wr_data;
    logic [DEPTH_W+1:0]     w_occupancy;
    logic                   w_full;
    logic                   w_push_ok;
    logic                   w_overrun_set;

    // A push still sitting in r_wr_en is not yet in the level, so count it here.
    assign w_occupancy   = {1'b0, io_fifo.level} + {{(DEPTH_W+1){1'b0}}, r_wr_en};
    assign w_full        = (w_occupancy >= (DEPTH_W+2)'(DEPTH));
    assign w_push_ok     = i_rx_valid & ~w_full;
    assign w_overrun_set = i_rx_valid & w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_push_ok;
            if (w_push_ok)
                r_wr_data <= i_rx_data;
        end
    end

    assign io_fifo.wr_en   = r_wr_en;
    assign io_fifo.wr_data = r_wr_data;

    // ---------------- pop FSM ----------------
    state_t         r_state;
    state_t         w_state_next;
    logic           r_empty;
    logic           w_rd_en;
    logic           w_rd_valid;
    logic           w_capture;
    logic [7:0]     r_rd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_valid   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rd_req)
                    w_state_next = ST_POP;
            end
            ST_POP: begin
                w_rd_en      = ~r_empty;
                w_state_next = ST_CAPT;
            end
            ST_CAPT: begin
                w_capture    = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_rd_valid   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Emptiness is frozen at request time so the read latency never depends on later pushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_empty   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (r_state == ST_IDLE && i_rd_req)
                r_empty <= (io_fifo.level == '0);
            if (w_capture)
                r_rd_data <= r_empty ? 8'h00 : io_fifo.rd_data[7:0];
        end
    end

    assign io_fifo.rd_en = w_rd_en;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = w_rd_valid;

    // ---------------- sticky flags ----------------
    logic [2:0] r_line_err;
    logic [2:0] w_line_set;
    logic       r_overrun;

    // Bits 8/9/10 of the popped word map to pe/fe/bi; a set beats a same-cycle clear.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_line_err
            assign w_line_set[gi] = w_capture & ~r_empty & io_fifo.rd_data[8+gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_line_err[gi] <= 1'b0;
                else
                    r_line_err[gi] <= w_line_set[gi] | (r_line_err[gi] & ~i_err_clr);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overrun <= 1'b0;
        else
            r_overrun <= w_overrun_set | (r_overrun & ~i_err_clr);
    end

    assign o_overrun = r_overrun;
    assign o_pe      = r_line_err[0];
    assign o_fe      = r_line_err[1];
    assign o_bi      = r_line_err[2];

    // ---------------- character timeout ----------------
    logic w_timeout;

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CHARS + 1);

    logic [TO_W-1:0]    r_to_cnt;
    logic [TO_W-1:0]    w_to_cnt_next;
    logic               r_timeout;
    logic               w_to_restart;

    assign w_to_restart = i_rx_valid | i_rd_req;

    always_comb begin
        w_to_cnt_next = r_to_cnt;
        if (w_to_restart || io_fifo.level == '0)
            w_to_cnt_next = '0;
        else if (i_char_tick && r_to_cnt != TO_W'(TO_CHARS))
            w_to_cnt_next = r_to_cnt + TO_W'(1);
    end

    // The flag outlives the counter: draining the FIFO does not clear it, only new activity does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_next;
            if (w_to_restart)
                r_timeout <= 1'b0;
            else if (w_to_cnt_next == TO_W'(TO_CHARS))
                r_timeout <= 1'b1;
        end
    end

    assign w_timeout = r_timeout;
`else
    logic w_unused_char_tick;

    assign w_unused_char_tick = i_char_tick;
    assign w_timeout          = 1'b0;
`endif

    assign o_timeout = w_timeout;

    // ---------------- level status / interrupt ----------------
    logic r_data_ready;
    logic r_irq_rx;
    logic w_level_hit;

    assign w_level_hit = (i_thresh != '0) && (io_fifo.level >= i_thresh);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_ready <= 1'b0;
            r_irq_rx     <= 1'b0;
        end else begin
            r_data_ready <= (io_fifo.level != '0);
            r_irq_rx     <= w_level_hit | w_timeout | r_overrun;
        end
    end

    assign o_data_ready = r_data_ready;
    assign o_irq_rx     = r_irq_rx;

endmodule
